seq_recognizer_param: RTL and testbench

//  Parametrised streaming character-sequence recognizer. Holds a runtime-

---
 rtl/seq_recognizer_param.sv | 109 ++++++++++
 tb/tb_seq_recognizer_param.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_recognizer_param.sv
// Streaming recognizer: compares a runtime-programmed pattern against a sliding window of the
// most recent characters and pulses match on each hit, with a saturating hit counter.
module seq_recognizer_param #(
  parameter int unsigned CHAR_W  = 7,
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned IDX_W  = $clog2(MAX_LEN),
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [CHAR_W-1:0] cfg_char,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              mode_ovl,
  input  logic              in_valid,
  input  logic [CHAR_W-1:0] in_char,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              armed
);

  logic [CHAR_W-1:0] win_q [MAX_LEN];
  logic [CHAR_W-1:0] win_d [MAX_LEN];
  logic [CHAR_W-1:0] pat_q [MAX_LEN];
  logic [CHAR_W-1:0] pat_d [MAX_LEN];
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  fill_q, fill_d;
  logic              match_q, match_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              shift, eq, hit;

  assign armed     = (len_q != '0) && (len_q <= LEN_W'(MAX_LEN));
  assign match     = match_q;
  assign match_cnt = cnt_q;

  always_comb begin
    win_d   = win_q;
    pat_d   = pat_q;
    len_d   = len_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;
    eq      = 1'b1;
    hit     = 1'b0;
    // A config write in the same cycle drops the input character.
    shift   = in_valid && !cfg_we;

    if (shift) begin
      win_d[0] = in_char;
      for (int k = 1; k < int'(MAX_LEN); k++) begin
        win_d[k] = win_q[k-1];
      end
      if (fill_q != LEN_W'(MAX_LEN)) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end

    // Oldest character of the last len entries lines up with pat[0].
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      int idx;
      idx = int'(len_q) - 1 - i;
      if (i < int'(len_q) && idx >= 0 && idx < int'(MAX_LEN)) begin
        if (win_d[idx[IDX_W-1:0]] != pat_q[i]) begin
          eq = 1'b0;
        end
      end
    end

    hit = shift && armed && (fill_d >= len_q) && eq;
    if (hit) begin
      match_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (!mode_ovl) begin
        fill_d = '0;
      end
    end

    if (cfg_we) begin
      if (int'(cfg_idx) < int'(MAX_LEN)) begin
        pat_d[cfg_idx] = cfg_char;
      end
      len_d  = cfg_len;
      fill_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      win_q   <= '{default: '0};
      pat_q   <= '{default: '0};
      len_q   <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      win_q   <= win_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_recognizer_param.sv
// Bench for seq_recognizer_param: directed scenarios plus random traffic, checked by a scoreboard
// fed from a history-queue reference model; a second instance exercises a 2-bit counter.
module tb_seq_recognizer_param;

  localparam int ML = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_idx = '0;
  logic [6:0] cfg_char = '0;
  logic [3:0] cfg_len = '0;
  logic       mode_ovl = 1'b1;
  logic       in_valid = 1'b0;
  logic [6:0] in_char = '0;
  logic       match, match2, armed, armed2;
  logic [7:0] cnt;
  logic [1:0] cnt2;

  always #5 CLK = ~CLK;

  seq_recognizer_param u_dut (
    .CLK(CLK), .RST(RST), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_char(cfg_char),
    .cfg_len(cfg_len), .mode_ovl(mode_ovl), .in_valid(in_valid), .in_char(in_char),
    .match(match), .match_cnt(cnt), .armed(armed)
  );

  seq_recognizer_param #(.CNT_W(2)) u_sat (
    .CLK(CLK), .RST(RST), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_char(cfg_char),
    .cfg_len(cfg_len), .mode_ovl(mode_ovl), .in_valid(in_valid), .in_char(in_char),
    .match(match2), .match_cnt(cnt2), .armed(armed2)
  );

  typedef struct packed {
    logic       m;
    logic [7:0] c;
    logic [1:0] c2;
    logic       a;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int errors = 0;

  // Reference model: pattern, length and the characters accepted since the last fill clear.
  logic [6:0] mpat [ML];
  int         mlen = 0;
  logic [6:0] hist[$];
  int         mcnt = 0;
  int         mcnt2 = 0;
  logic       ovl = 1'b1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  always @(posedge CLK) begin
    exp_t e;
    #2;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("match", {7'd0, match}, {7'd0, e.m});
      chk("match_cnt", cnt, e.c);
      chk("match_sat", {7'd0, match2}, {7'd0, e.m});
      chk("match_cnt_sat", {6'd0, cnt2}, {6'd0, e.c2});
      chk("armed", {7'd0, armed}, {7'd0, e.a});
      chk("armed_sat", {7'd0, armed2}, {7'd0, e.a});
    end
  end

  task automatic step(input logic rst, input logic we, input int idx, input logic [6:0] ch,
                      input int clen, input logic v, input logic [6:0] c);
    exp_t e;
    logic m;
    RST      = rst;
    cfg_we   = we;
    cfg_idx  = 3'(idx);
    cfg_char = ch;
    cfg_len  = 4'(clen);
    mode_ovl = ovl;
    in_valid = v;
    in_char  = c;
    m = 1'b0;
    if (rst) begin
      for (int i = 0; i < ML; i++) mpat[i] = '0;
      mlen = 0; hist = {}; mcnt = 0; mcnt2 = 0;
    end else if (we) begin
      mpat[idx] = ch; mlen = clen; hist = {};
    end else if (v) begin
      hist.push_back(c);
      if (hist.size() > ML) void'(hist.pop_front());
      if (mlen >= 1 && mlen <= ML && hist.size() >= mlen) begin
        m = 1'b1;
        for (int i = 0; i < mlen; i++)
          if (hist[hist.size() - mlen + i] != mpat[i]) m = 1'b0;
      end
      if (m) begin
        if (mcnt < 255) mcnt++;
        if (mcnt2 < 3) mcnt2++;
        if (!ovl) hist = {};
      end
    end
    e.m  = m;
    e.c  = 8'(mcnt);
    e.c2 = 2'(mcnt2);
    e.a  = (mlen >= 1 && mlen <= ML);
    expq.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 0, 7'd0, 0, 1'b0, 7'd0);
  endtask

  task automatic write_pat(input string s, input int len);
    byte b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      step(1'b0, 1'b1, i, b[6:0], len, 1'b0, 7'd0);
    end
  endtask

  task automatic feed(input string s);
    byte b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      step(1'b0, 1'b0, 0, 7'd0, 0, 1'b1, b[6:0]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 7'd0, 0, 1'b0, 7'd0);
  endtask

  initial begin
    byte b;
    // Overlapping then non-overlapping on "ABA".
    ovl = 1'b1; do_reset(); write_pat("ABA", 3); feed("ABABA"); idle(1);
    ovl = 1'b0; do_reset(); write_pat("ABA", 3); feed("ABABA"); idle(1);
    // Idle cycles inside a match.
    ovl = 1'b1; do_reset(); write_pat("JAMES", 5); feed("JA"); idle(3); feed("MES"); idle(1);
    // Zero length disarms; mid-stream rewrite drops the partial prefix.
    do_reset(); write_pat("A", 0); feed("ABA"); idle(1);
    do_reset(); write_pat("ABA", 3); feed("AB");
    step(1'b0, 1'b1, 2, 7'h41, 3, 1'b1, 7'h41); feed("ABA"); idle(1);
    // Length above MAX_LEN disarms.
    do_reset(); write_pat("A", 9); feed("AAA");
    // 2-bit counter saturation with len=1, non-overlapping.
    ovl = 1'b0; do_reset(); write_pat("Z", 1); feed("ZZZZZ"); idle(1);
    // Reset on the completing character.
    ovl = 1'b1; do_reset(); write_pat("ABA", 3); feed("AB");
    step(1'b1, 1'b0, 0, 7'd0, 0, 1'b1, 7'h41); idle(1);
    // 8-bit counter saturation.
    do_reset(); write_pat("A", 1);
    for (int i = 0; i < 260; i++) feed("A");
    // Random traffic over a small alphabet so hits are frequent.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic r, w, v;
      int   idx, clen;
      r    = ($urandom_range(0, 399) == 0);
      w    = ($urandom_range(0, 19) == 0);
      v    = ($urandom_range(0, 9) < 7);
      idx  = $urandom_range(0, 3);
      clen = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4);
      if ($urandom_range(0, 49) == 0) ovl = ~ovl;
      b = byte'(8'h41 + $urandom_range(0, 1));
      step(r, w, idx, b[6:0], clen, v, 7'(8'h41 + $urandom_range(0, 1)));
    end
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge CLK);
    #3;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
